// File: rtl/addsub_accum.sv
// addsub_accum: command-driven accumulator wrapped around an external
// combinational AddSub unit. Commands arrive over valid/ready; ADD/SUB hold
// the AddSub operands stable for SETTLE_CYCLES cycles before the result,
// carry and overflow are captured. Overflow is also kept as a sticky flag
// that only CLEAR or reset removes.
module addsub_accum #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] as_A,
  output logic [7:0] as_B,
  output logic       as_Ci,
  input  logic [7:0] as_SD,
  input  logic       as_Co,
  input  logic       as_Err,
  output logic [7:0] acc,
  output logic       res_valid,
  output logic       res_co,
  output logic       res_err,
  output logic       ovf_sticky
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_ADD   = 2'd2,
    OP_SUB   = 2'd3
  } op_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  op_t        op_r;
  logic [7:0] opnd_r;
  logic [3:0] cnt;

  // Handshake and status decode straight from the state register. cmd_ready
  // is also masked by reset so it reads 0 while reset is held and 1 in the
  // very first cycle after release.
  assign cmd_ready = (state == IDLE) && !reset;
  assign res_valid = (state == DONE);
  assign as_A      = acc;
  assign as_B      = opnd_r;
  assign as_Ci     = (state == EXEC) && (op_r == OP_SUB);

  // Command FSM: accept, settle the AddSub inputs, capture, then report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_r       <= OP_CLEAR;
      opnd_r     <= '0;
      cnt        <= '0;
      acc        <= '0;
      res_co     <= 1'b0;
      res_err    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_r   <= op_t'(cmd_op);
            opnd_r <= cmd_data;
            case (op_t'(cmd_op))
              OP_CLEAR: begin
                acc        <= '0;
                res_co     <= 1'b0;
                res_err    <= 1'b0;
                ovf_sticky <= 1'b0;
                state      <= DONE;
              end
              OP_LOAD: begin
                acc     <= cmd_data;
                res_co  <= 1'b0;
                res_err <= 1'b0;
                state   <= DONE;
              end
              default: begin
                cnt   <= CNT_INIT;
                state <= EXEC;
              end
            endcase
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            acc        <= as_SD;
            res_co     <= as_Co;
            res_err    <= as_Err;
            ovf_sticky <= ovf_sticky | as_Err;
            state      <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_accum.sv
// Bench for addsub_accum: two instances (settle 1 and settle 4), each fed by
// a small combinational AddSub model, checked against an arithmetic model of
// the accumulator.
module tb_addsub_accum;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [1:0] cmd_op    [2];
  logic [7:0] cmd_data  [2];
  logic [7:0] as_A      [2];
  logic [7:0] as_B      [2];
  logic       as_Ci     [2];
  logic [7:0] as_SD     [2];
  logic       as_Co     [2];
  logic       as_Err    [2];
  logic [7:0] acc       [2];
  logic       res_valid [2];
  logic       res_co    [2];
  logic       res_err   [2];
  logic       ovf_sticky[2];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned m_acc  [2];
  bit          m_ovf  [2];
  int unsigned settle [2];

  always #5 clk = ~clk;

  // External AddSub unit: A + (Ci ? ~B : B) + Ci
  for (genvar g = 0; g < 2; g++) begin : g_addsub
    logic [7:0] bx;
    logic [8:0] s;
    assign bx        = as_Ci[g] ? ~as_B[g] : as_B[g];
    assign s         = {1'b0, as_A[g]} + {1'b0, bx} + {8'b0, as_Ci[g]};
    assign as_SD[g]  = s[7:0];
    assign as_Co[g]  = s[8];
    assign as_Err[g] = (as_A[g][7] == bx[7]) && (s[7] != as_A[g][7]);
  end

  addsub_accum #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_data(cmd_data[0]),
    .as_A(as_A[0]), .as_B(as_B[0]), .as_Ci(as_Ci[0]),
    .as_SD(as_SD[0]), .as_Co(as_Co[0]), .as_Err(as_Err[0]),
    .acc(acc[0]), .res_valid(res_valid[0]), .res_co(res_co[0]),
    .res_err(res_err[0]), .ovf_sticky(ovf_sticky[0])
  );

  addsub_accum #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_data(cmd_data[1]),
    .as_A(as_A[1]), .as_B(as_B[1]), .as_Ci(as_Ci[1]),
    .as_SD(as_SD[1]), .as_Co(as_Co[1]), .as_Err(as_Err[1]),
    .acc(acc[1]), .res_valid(res_valid[1]), .res_co(res_co[1]),
    .res_err(res_err[1]), .ovf_sticky(ovf_sticky[1])
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_signed8(input int unsigned v);
    return (v > 127) ? int'(v) - 256 : int'(v);
  endfunction

  // Issue one command on instance d and check the full result against the model.
  task automatic do_cmd(input int unsigned d, input logic [1:0] op, input logic [7:0] data);
    int unsigned n, lat, pre, dv, exp_acc, sum;
    bit exp_co, exp_err;
    int r;
    n = 0;
    while (!cmd_ready[d] && n < 64) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", 32'(cmd_ready[d]), 1);
    pre = m_acc[d];
    dv  = 32'(data);
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = op;
    cmd_data[d]  = data;
    @(posedge clk); #1;
    cmd_valid[d] = 1'b0;
    cmd_op[d]    = 2'($urandom);
    cmd_data[d]  = 8'($urandom);
    lat = 0;
    while (!res_valid[d] && lat < 64) begin
      check("exec_A", 32'(as_A[d]), pre);
      check("exec_B", 32'(as_B[d]), dv);
      check("exec_Ci", 32'(as_Ci[d]), (op == 2'd3) ? 1 : 0);
      check("exec_rdy", 32'(cmd_ready[d]), 0);
      @(posedge clk); #1; lat++;
    end
    exp_co  = 1'b0;
    exp_err = 1'b0;
    case (op)
      2'd0: begin exp_acc = 0; m_ovf[d] = 1'b0; end
      2'd1: exp_acc = dv;
      2'd2: begin
        sum     = pre + dv;
        exp_acc = sum % 256;
        exp_co  = (sum > 255);
        r       = to_signed8(pre) + to_signed8(dv);
        exp_err = (r > 127) || (r < -128);
      end
      default: begin
        exp_acc = (pre + 256 - dv) % 256;
        exp_co  = (pre >= dv);
        r       = to_signed8(pre) - to_signed8(dv);
        exp_err = (r > 127) || (r < -128);
      end
    endcase
    m_ovf[d] = m_ovf[d] | exp_err;
    m_acc[d] = exp_acc;
    check("latency", lat, (op >= 2'd2) ? settle[d] : 0);
    check("res_valid", 32'(res_valid[d]), 1);
    check("acc", 32'(acc[d]), exp_acc);
    check("res_co", 32'(res_co[d]), 32'(exp_co));
    check("res_err", 32'(res_err[d]), 32'(exp_err));
    check("ovf_sticky", 32'(ovf_sticky[d]), 32'(m_ovf[d]));
    @(posedge clk); #1;
    check("pulse_end", 32'(res_valid[d]), 0);
    check("ready_back", 32'(cmd_ready[d]), 1);
  endtask

  initial begin
    int unsigned accepts, ex, n;
    settle[0] = 1;
    settle[1] = 4;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_op[i]    = 2'd0;
      cmd_data[i]  = 8'd0;
      m_acc[i]     = 0;
      m_ovf[i]     = 1'b0;
    end

    // Reset state
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 32'(cmd_ready[i]), 0);
      check("rst_acc", 32'(acc[i]), 0);
      check("rst_asB", 32'(as_B[i]), 0);
      check("rst_asCi", 32'(as_Ci[i]), 0);
      check("rst_valid", 32'(res_valid[i]), 0);
      check("rst_co", 32'(res_co[i]), 0);
      check("rst_err", 32'(res_err[i]), 0);
      check("rst_ovf", 32'(ovf_sticky[i]), 0);
    end
    reset = 1'b0;
    #1;
    check("ready_after_rst0", 32'(cmd_ready[0]), 1);
    check("ready_after_rst1", 32'(cmd_ready[1]), 1);

    // Directed sequences on the settle-1 instance
    do_cmd(0, 2'd1, 8'h05); do_cmd(0, 2'd2, 8'h03);
    do_cmd(0, 2'd1, 8'hFF); do_cmd(0, 2'd2, 8'h01);
    do_cmd(0, 2'd1, 8'h7F); do_cmd(0, 2'd2, 8'h01);
    do_cmd(0, 2'd3, 8'h01);
    check("sticky_held", 32'(ovf_sticky[0]), 1);
    do_cmd(0, 2'd1, 8'h10);
    check("sticky_after_load", 32'(ovf_sticky[0]), 1);
    do_cmd(0, 2'd0, 8'hAA);
    do_cmd(0, 2'd1, 8'h00); do_cmd(0, 2'd3, 8'h01);
    do_cmd(0, 2'd3, 8'h80); do_cmd(0, 2'd2, 8'h80);

    // Random commands on both instances, arithmetic weighted heavier
    for (int i = 0; i < 60; i++) begin
      int unsigned sel;
      logic [1:0] op;
      sel = $urandom_range(0, 9);
      op  = (sel == 0) ? 2'd0 : (sel < 3) ? 2'd1 : (sel < 6) ? 2'd2 : 2'd3;
      do_cmd(32'(i % 2), op, 8'($urandom));
    end

    // Continuous valid, settle 4: one accept every 6 cycles
    do_cmd(1, 2'd0, 8'h00);
    cmd_valid[1] = 1'b1;
    cmd_op[1]    = 2'd2;
    cmd_data[1]  = 8'h01;
    accepts = 0;
    ex      = 0;
    for (int i = 0; i < 18; i++) begin
      if (cmd_ready[1]) accepts++;
      else if (!res_valid[1]) begin
        ex++;
        check("strm_A", 32'(as_A[1]), accepts - 1);
        check("strm_B", 32'(as_B[1]), 1);
        check("strm_Ci", 32'(as_Ci[1]), 0);
      end
      @(posedge clk); #1;
    end
    cmd_valid[1] = 1'b0;
    check("strm_accepts", accepts, 3);
    check("strm_exec_cycles", ex, 12);
    check("strm_acc", 32'(acc[1]), 3);
    m_acc[1] = 3;

    // Reset during EXEC of ADD 0x10 on acc 0x20
    do_cmd(1, 2'd1, 8'h20);
    cmd_valid[1] = 1'b1;
    cmd_op[1]    = 2'd2;
    cmd_data[1]  = 8'h10;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_exec", 32'(cmd_ready[1]), 0);
    reset = 1'b1;
    #1;
    check("abort_acc", 32'(acc[1]), 0);
    check("abort_asB", 32'(as_B[1]), 0);
    check("abort_ready", 32'(cmd_ready[1]), 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (res_valid[1]) n++;
    end
    check("abort_no_valid", n, 0);
    reset = 1'b0;
    #1;
    check("abort_ready_rel", 32'(cmd_ready[1]), 1);
    check("abort_acc_rel", 32'(acc[1]), 0);
    @(posedge clk); #1;
    check("abort_no_valid2", 32'(res_valid[1]), 0);
    check("abort_ovf", 32'(ovf_sticky[1]), 0);
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
    do_cmd(1, 2'd2, 8'h10);
    do_cmd(0, 2'd3, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
